// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, 2-entry skid buffer, synchronous flush.
// Optional perf counters (stall_cycles, bubble_cycles) are built only when PIPE_REG_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned LANES          = 32'd4,
  parameter int unsigned LANE_W         = 32'd32,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W          = 32'd16,
  localparam int unsigned DATA_W        = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_REG_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  bubble_cycles
`endif
);

  logic              main_v_r;
  logic [DATA_W-1:0] main_d_r;
  logic              skid_v_r;
  logic [DATA_W-1:0] skid_d_r;
  logic              in_ready_r;

  logic              main_v_s;
  logic [DATA_W-1:0] main_d_s;
  logic              skid_v_s;
  logic [DATA_W-1:0] skid_d_s;
  logic              in_ready_s;

  logic              acc_s;
  logic              fire_s;
  logic              main_free_s;

  // Handshake events seen at the coming clock edge.
  always_comb begin
    acc_s       = in_valid & in_ready_r;
    fire_s      = main_v_r & out_ready;
    main_free_s = ~main_v_r | fire_s;
  end

  // Next-state selection; flush wins over every other move.
  always_comb begin
    main_v_s = main_v_r;
    main_d_s = main_d_r;
    skid_v_s = skid_v_r;
    skid_d_s = skid_d_r;
    if (flush) begin
      main_v_s = 1'b0;
      skid_v_s = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        main_d_s = {DATA_W{1'b0}};
        skid_d_s = {DATA_W{1'b0}};
      end else begin
        main_d_s = main_d_r;
        skid_d_s = skid_d_r;
      end
    end else if (main_free_s) begin
      if (skid_v_r) begin
        main_v_s = 1'b1;
        main_d_s = skid_d_r;
        if (acc_s) begin
          skid_v_s = 1'b1;
          skid_d_s = in_data;
        end else begin
          skid_v_s = 1'b0;
          skid_d_s = skid_d_r;
        end
      end else begin
        // Empty main keeps its last payload so out_data stays stable while idle.
        if (acc_s) begin
          main_v_s = 1'b1;
          main_d_s = in_data;
        end else begin
          main_v_s = 1'b0;
          main_d_s = main_d_r;
        end
      end
    end else if (acc_s) begin
      skid_v_s = 1'b1;
      skid_d_s = in_data;
    end else begin
      main_v_s = main_v_r;
      skid_v_s = skid_v_r;
    end
    in_ready_s = ~skid_v_s;
  end

  // Stage state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_v_r   <= 1'b0;
      main_d_r   <= {DATA_W{1'b0}};
      skid_v_r   <= 1'b0;
      skid_d_r   <= {DATA_W{1'b0}};
      in_ready_r <= 1'b0;
    end else begin
      main_v_r   <= main_v_s;
      main_d_r   <= main_d_s;
      skid_v_r   <= skid_v_s;
      skid_d_r   <= skid_d_s;
      in_ready_r <= in_ready_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = main_v_r;
  assign out_data  = main_d_r;

`ifdef PIPE_REG_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] bubble_cnt_r;

  // Saturating stall/bubble counters; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r  <= {CNT_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (main_v_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (!main_v_r && (bubble_cnt_r != {CNT_W{1'b1}})) begin
        bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end

  assign stall_cycles  = stall_cnt_r;
  assign bubble_cycles = bubble_cnt_r;
`else
  // CNT_W only sizes the perf counters, which this build leaves out.
  if (CNT_W == 32'd0) begin : g_no_perf
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg (reset, stream, skid, flush, async reset, perf counters
// when PIPE_REG_PERF_EN is defined).
module tb_pipe_stage_reg;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          nc_in_ready;
  logic          nc_out_valid;
  logic [DW-1:0] nc_out_data;
`ifdef PIPE_REG_PERF_EN
  logic [3:0]    stall_cycles;
  logic [3:0]    bubble_cycles;
  logic [3:0]    nc_stall_cycles;
  logic [3:0]    nc_bubble_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.LANES(4), .LANE_W(32), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_REG_PERF_EN
    , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
  );

  pipe_stage_reg #(.LANES(4), .LANE_W(32), .CLEAR_ON_FLUSH(1'b0), .CNT_W(4)) dut_nc (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(nc_in_ready), .in_data(in_data),
    .out_valid(nc_out_valid), .out_ready(out_ready), .out_data(nc_out_data)
`ifdef PIPE_REG_PERF_EN
    , .stall_cycles(nc_stall_cycles), .bubble_cycles(nc_bubble_cycles)
`endif
  );

  function automatic logic [DW-1:0] mk(input int unsigned i);
    logic [31:0] v;
    v = i;
    return {~v, v + 32'd100, v << 2, v};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard step: score the edge's handshakes, then advance to 1 time unit after the edge.
  task automatic tick();
    logic acc, fire;
    logic [DW-1:0] exp;
    acc  = in_valid & in_ready;
    fire = out_valid & out_ready;
    if (fire) begin
      check("sb_nonempty", DW'(sb.size() != 0), DW'(1));
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("sb_out_data", out_data, exp);
      end
    end
    if (flush) sb.delete();
    else if (acc) sb.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. Reset held with in_valid asserted
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = mk(99); out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(0));
    check("rst_out_data", out_data, '0);
    reset = 1'b1;
    in_valid = 1'b0;
    check("rel_in_ready_low", DW'(in_ready), DW'(0));
    @(posedge clk);
    #1;
    check("rel_in_ready_high", DW'(in_ready), DW'(1));

    // 2. Back-to-back stream, one-cycle latency
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = mk(i);
      check("stream_in_ready", DW'(in_ready), DW'(1));
      tick();
      check("stream_out_valid", DW'(out_valid), DW'(1));
      check("stream_out_data", out_data, mk(i));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", DW'(out_valid), DW'(0));
    check("stream_sb_empty", DW'(sb.size()), DW'(0));

    // 3. Stall fills the skid, then drains in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'hA);
    tick();
    check("skid_ready_after_A", DW'(in_ready), DW'(1));
    in_data = mk(32'hB);
    tick();
    check("skid_ready_after_B", DW'(in_ready), DW'(0));
    in_data = mk(32'hC);
    tick();
    tick();
    check("skid_hold_valid", DW'(out_valid), DW'(1));
    check("skid_hold_data", out_data, mk(32'hA));
    check("skid_hold_ready", DW'(in_ready), DW'(0));
    out_ready = 1'b1;
    tick();
    check("drain_B", out_data, mk(32'hB));
    check("drain_ready", DW'(in_ready), DW'(1));
    tick();
    check("drain_C", out_data, mk(32'hC));
    in_valid = 1'b0;
    tick();
    check("drain_empty", DW'(out_valid), DW'(0));

    // 4. Flush with main and skid full
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'h1A);
    tick();
    in_data = mk(32'h1B);
    tick();
    in_data = mk(32'h1C); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", DW'(out_valid), DW'(0));
    check("flush_in_ready", DW'(in_ready), DW'(1));
    check("flush_out_data_zero", out_data, '0);
    check("flush_nc_out_valid", DW'(nc_out_valid), DW'(0));
    check("flush_nc_out_data", nc_out_data, mk(32'h1A));
    // accepted in a flush cycle -> discarded
    in_valid = 1'b1; in_data = mk(32'h1C); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_acc_dropped0", DW'(out_valid), DW'(0));
    tick();
    check("flush_acc_dropped1", DW'(out_valid), DW'(0));
    check("flush_sb_empty", DW'(sb.size()), DW'(0));

    // 5. Asynchronous reset mid-stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'h2A);
    tick();
    in_data = mk(32'h2B);
    tick();
    in_valid = 1'b0;
    check("pre_areset_valid", DW'(out_valid), DW'(1));
    #3;
    reset = 1'b0;
    #1;
    check("areset_out_valid", DW'(out_valid), DW'(0));
    check("areset_in_ready", DW'(in_ready), DW'(0));
    check("areset_out_data", out_data, '0);
    sb.delete();
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("areset_rel_ready", DW'(in_ready), DW'(1));

`ifdef PIPE_REG_PERF_EN
    // 6. Saturating stall counter, unaffected by flush
    in_valid = 1'b1; in_data = mk(32'h3A);
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    check("perf_stall_sat", DW'(stall_cycles), DW'(15));
    check("perf_bubble", DW'(bubble_cycles), DW'(2));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("perf_stall_flush", DW'(stall_cycles), DW'(15));
    check("perf_bubble_flush", DW'(bubble_cycles), DW'(2));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
